freq_meter: RTL

//  Measures the frequency of an asynchronous slow input (key/sensor/divided

---
 rtl/freq_meter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over GATE_CYCLES clk; FREQ_METER_AUTO_EN selects continuous re-gating.
// Latency: result and valid appear GATE_CYCLES+1 clk after start; edge path is 2-flop sync + prev flop.
// Backpressure: none; start is dropped while busy, results are overwritten by the next run.
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               w_edge;
    logic               w_gate_last;
    logic               w_clear;
    logic [CNT_W-1:0]   w_edge_cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge      = r_sync2 & ~r_prev;
    assign w_gate_last = (r_gate_cnt == GATE_W'(GATE_CYCLES - 1));
    // Saturating increment; the final-cycle value feeds the result so a last-cycle edge counts.
    assign w_edge_cnt_inc = (w_edge && !(&r_edge_cnt)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

`ifdef FREQ_METER_AUTO_EN
    logic w_unused_start;
    assign w_unused_start = start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef FREQ_METER_AUTO_EN
                w_next  = GATE;
                w_clear = 1'b1;
`else
                if (start) begin
                    w_next  = GATE;
                    w_clear = 1'b1;
                end
`endif
            end
            GATE: begin
                if (w_gate_last) w_next = DONE;
            end
            DONE: begin
`ifdef FREQ_METER_AUTO_EN
                w_next  = GATE;
                w_clear = 1'b1;
`else
                w_next  = IDLE;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else if (w_clear) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (r_state == GATE) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_edge_cnt_inc;
            if (w_gate_last) begin
                r_count <= w_edge_cnt_inc;
                r_ovf   <= &w_edge_cnt_inc;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign valid = (r_state == DONE);
    assign count = r_count;
    assign ovf   = r_ovf;

endmodule
